// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR sample-path FIFO blocks.
package fir_pkg;

    localparam int FIR_SAMPLE_W = 16;

    // Pointer-advance decode: bit 1 = read side advances, bit 0 = write side advances
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fir_fifo_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Storage has no reset; only the read register clears on rst.
module fir_fifo_ram #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 64,
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fir_sample_fifo.sv
// Single-clock sample FIFO with occupancy count, almost flags and sticky error flags.
// Define FIR_FIFO_FWFT_EN for first-word-fall-through reads (head word prefetched into dout).
module fir_sample_fifo
    import fir_pkg::*;
#(
    parameter int DWIDTH    = FIR_SAMPLE_W,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DWIDTH-1:0]            din,
    input  logic                         rd_en,
    output logic [DWIDTH-1:0]            dout,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

    logic [PTR_W:0]   wptr;
    logic [PTR_W:0]   rptr;
    logic [CNT_W-1:0] ptr_diff;
    logic             wr_ok;
    logic             rd_ok;
    logic             ram_rd;
    logic             ram_wr;
    fifo_op_e         op;

    assign ptr_diff = wptr - rptr;
    assign wr_ok    = wr_en && !full;

`ifdef FIR_FIFO_FWFT_EN
    // rptr addresses the next RAM word not yet in the output register,
    // so the prefetched head word is counted separately via out_valid.
    logic out_valid;
    logic ram_has_word;

    assign ram_has_word = (ptr_diff != '0);
    assign rd_ok        = rd_en && out_valid;
    assign ram_rd       = ram_has_word && (!out_valid || rd_ok);
    assign count        = ptr_diff + CNT_W'(out_valid);
    assign empty        = !out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (ram_rd) begin
            out_valid <= 1'b1;
        end else if (rd_ok) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign count  = ptr_diff;
    assign empty  = (ptr_diff == '0);
    assign rd_ok  = rd_en && !empty;
    assign ram_rd = rd_ok;
`endif

    assign full         = (count == FULL_LVL);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign ram_wr = wr_ok && !rst;
    assign op     = fifo_op_e'({ram_rd, wr_ok});

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            unique case (op)
                OP_WRITE: wptr <= wptr + PTR_ONE;
                OP_READ:  rptr <= rptr + PTR_ONE;
                OP_BOTH: begin
                    wptr <= wptr + PTR_ONE;
                    rptr <= rptr + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    fir_fifo_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_wr),
        .wr_addr (wptr[PTR_W-1:0]),
        .wr_data (din),
        .rd_en   (ram_rd),
        .rd_addr (rptr[PTR_W-1:0]),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Randomised self-checking bench for fir_sample_fifo against a queue-based reference model.
module tb_fir_sample_fifo;

    localparam int DWIDTH    = 16;
    localparam int DEPTH     = 64;
    localparam int AF_THRESH = 56;
    localparam int AE_THRESH = 8;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

`ifdef FIR_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DWIDTH-1:0] din;
    logic              rd_en;
    logic [DWIDTH-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    fir_sample_fifo #(
        .DWIDTH    (DWIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: every word held, visible head word (FWFT), sticky flags, output word
    logic [DWIDTH-1:0] q[$];
    logic [DWIDTH-1:0] m_dout;
    bit                m_avail;
    bit                m_ovf;
    bit                m_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_empty();
        return FWFT ? !m_avail : (q.size() == 0);
    endfunction

    // In FWFT mode a word becomes visible once it was written before the current edge.
    task automatic model_edge(input bit w, input logic [DWIDTH-1:0] d, input bit r, input bit rs);
        int n;
        bit was_empty;
        logic [DWIDTH-1:0] popped;
        n = q.size();
        was_empty = model_empty();
        if (rs) begin
            q.delete();
            m_dout  = '0;
            m_avail = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            if (w && n == DEPTH) m_ovf = 1'b1;
            if (r && was_empty)  m_udf = 1'b1;
            if (r && !was_empty) begin
                popped = q.pop_front();
                if (!FWFT) m_dout = popped;
            end
            if (FWFT) begin
                m_avail = (q.size() != 0);
                if (m_avail) m_dout = q[0];
            end
            if (w && n != DEPTH) q.push_back(d);
        end
    endtask

    task automatic compare();
        int n;
        n = q.size();
        check("count",        32'(count),        32'(n));
        check("empty",        32'(empty),        32'(model_empty()));
        check("full",         32'(full),         32'(n == DEPTH));
        check("almost_full",  32'(almost_full),  32'(n >= AF_THRESH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE_THRESH));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
        check("dout",         32'(dout),         32'(m_dout));
    endtask

    task automatic step(input bit w, input logic [DWIDTH-1:0] d, input bit r, input bit rs);
        wr_en = w;
        din   = d;
        rd_en = r;
        rst   = rs;
        @(posedge clk);
        model_edge(w, d, r, rs);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [DWIDTH-1:0] v;
        int wp;
        int rp;

        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        rst   = 1'b1;
        q.delete();
        m_dout = '0; m_avail = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

        // Reset state, then fill to full and one write past full
        step(0, '0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, DWIDTH'(i), 0, 0);
        step(1, 16'hBEEF, 0, 0);
        step(0, '0, 0, 0);

        // Drain everything in order, then one read past empty
        for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Steady simultaneous read/write at count 5 across pointer wrap
        step(0, '0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, DWIDTH'(16'h1000 + i), 0, 0);
        step(0, '0, 0, 0);
        for (int i = 5; i < 205; i++) step(1, DWIDTH'(16'h1000 + i), 1, 0);

        // Read+write on empty, then read+write on full
        step(0, '0, 0, 1);
        step(1, 16'hA5A5, 1, 0);
        step(0, '0, 0, 0);
        for (int i = 1; i < DEPTH; i++) step(1, DWIDTH'(16'h2000 + i), 0, 0);
        step(0, '0, 0, 0);
        step(1, 16'h7777, 1, 0);
        step(0, '0, 0, 0);

        // Single write into empty, no read: fall-through vs hold
        step(0, '0, 0, 1);
        step(1, 16'h1234, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);

        // Reset mid-stream at count 30 with both requests high
        step(0, '0, 0, 1);
        for (int i = 0; i < 30; i++) step(1, DWIDTH'(16'h3000 + i), 0, 0);
        step(1, 16'h3FFF, 1, 1);
        step(1, 16'h4001, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);

        // Randomised traffic with phases of varying write/read bias
        step(0, '0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                wp = $urandom_range(10, 90);
                rp = $urandom_range(10, 90);
            end
            v = DWIDTH'($urandom);
            step($urandom_range(0, 99) < wp, v, $urandom_range(0, 99) < rp,
                 $urandom_range(0, 499) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
